// File: rtl/rdm_tx.sv
// Serialises the 9-byte deposit message "RDM-SU<n>-#" as 8N1 UART; tx goes low one cycle after a request is accepted.
// Requests are only taken in IDLE and before done; busy reports when they would be dropped.
module rdm_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       deposit_req,
    output logic       tx,
    output logic       RDM_active,
    output logic [1:0] subunit,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sub_q, sub_d;
    logic          done_q, done_d;

    logic [7:0]    cur_byte;
    logic          bit_end;

    // Byte 6 is the only variable character: ASCII digit of the subunit.
    function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [1:0] su);
        case (idx)
            4'd0:    msg_byte = 8'h52;
            4'd1:    msg_byte = 8'h44;
            4'd2:    msg_byte = 8'h4D;
            4'd3:    msg_byte = 8'h2D;
            4'd4:    msg_byte = 8'h53;
            4'd5:    msg_byte = 8'h55;
            4'd6:    msg_byte = {6'b001100, su};
            4'd7:    msg_byte = 8'h2D;
            default: msg_byte = 8'h23;
        endcase
    endfunction

    assign cur_byte = msg_byte(byte_q, sub_q);
    assign bit_end  = (cnt_q == CNT_MAX);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            sub_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        sub_d      = sub_q;
        done_d     = done_q;
        tx         = 1'b1;
        RDM_active = 1'b0;
        case (state_q)
            IDLE: begin
                if (deposit_req && !done_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                tx         = 1'b0;
                RDM_active = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tx         = cur_byte[bit_q];
                RDM_active = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                RDM_active = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    // Next start bit follows immediately: frames are back-to-back.
                    if (byte_q == LAST_BYTE) begin
                        state_d = FINISH;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                if (sub_q == 2'd3) begin
                    done_d = 1'b1;
                end else begin
                    sub_d = sub_q + 2'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign subunit = sub_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_rdm_tx.sv
// Randomised scoreboard bench for rdm_tx: a fast instance (4 clocks/bit) and a default-rate instance.
`timescale 1ns/1ps
module tb_rdm_tx;

    localparam int C0 = 4;
    localparam int C1 = 434;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, req0, tx0, act0, busy0, done0;
    logic       rst1, req1, tx1, act1, busy1, done1;
    logic [1:0] sub0, sub1;

    rdm_tx #(.CLKS_PER_BIT(C0)) dut0 (
        .clk_50M(clk), .reset(rst0), .deposit_req(req0), .tx(tx0),
        .RDM_active(act0), .subunit(sub0), .busy(busy0), .done(done0)
    );

    rdm_tx dut1 (
        .clk_50M(clk), .reset(rst1), .deposit_req(req1), .tx(tx1),
        .RDM_active(act1), .subunit(sub1), .busy(busy1), .done(done1)
    );

    typedef struct {
        int sub;
        int gap;
    } msg_t;

    logic [7:0] bq [2][$];
    msg_t       dq [2][$];

    int n_chk = 0;
    int n_err = 0;
    int m_sub = 0;
    int m_done = 0;

    bit         rx_busy [2];
    bit         rx_have [2];
    int         rx_cnt [2];
    int         rx_bad [2];
    logic [7:0] rx_exp [2];
    logic [7:0] rx_byte [2];
    bit         prev_act [2];
    bit         post [2];
    int         post_sub [2];
    int         act_len [2];
    int         cyc [2];
    int         fall_cyc [2];
    int         rise_sub [2];
    int         sub_bad [2];
    int         sub3cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_msg(input int k, input int sub, input int gap);
        string s;
        msg_t  m;
        s = $sformatf("RDM-SU%0d-#", sub);
        for (int i = 0; i < s.len(); i++) bq[k].push_back(s.getc(i));
        m.sub = sub;
        m.gap = gap;
        dq[k].push_back(m);
    endtask

    task automatic mon(input int k, input logic r, input logic t, input logic a,
                       input logic [1:0] s, input logic d);
        msg_t m;
        logic e;
        int   pos;
        int   c;
        c = (k == 0) ? C0 : C1;
        if (r) begin
            rx_busy[k]  = 1'b0;
            prev_act[k] = 1'b0;
            post[k]     = 1'b0;
            bq[k].delete();
            dq[k].delete();
            return;
        end
        cyc[k]++;
        if (k == 0 && s == 2'd3 && a) sub3cnt++;
        if (post[k]) begin
            chk("subunit after msg", 32'(s), (post_sub[k] < 3) ? post_sub[k] + 1 : 3);
            chk("done after msg", 32'(d), 32'(post_sub[k] == 3));
            post[k] = 1'b0;
        end
        if (a && !prev_act[k]) begin
            act_len[k]  = 0;
            sub_bad[k]  = 0;
            rise_sub[k] = int'(s);
            if (dq[k].size() == 0) begin
                chk("unexpected message", 1, 0);
            end else begin
                chk("subunit at msg start", 32'(s), dq[k][0].sub);
                if (dq[k][0].gap > 0) chk("idle gap between msgs", cyc[k] - fall_cyc[k], dq[k][0].gap);
            end
        end
        if (a) begin
            act_len[k]++;
            if (int'(s) != rise_sub[k]) sub_bad[k]++;
        end
        if (!a && prev_act[k]) begin
            chk("active length", act_len[k], 90 * c);
            chk("subunit stable in msg", sub_bad[k], 0);
            chk("tx idle in FINISH", 32'(t), 1);
            if (dq[k].size() > 0) begin
                m           = dq[k].pop_front();
                post[k]     = 1'b1;
                post_sub[k] = m.sub;
            end
            fall_cyc[k] = cyc[k];
        end
        prev_act[k] = a;

        if (!rx_busy[k] && t == 1'b0) begin
            rx_busy[k] = 1'b1;
            rx_cnt[k]  = 0;
            rx_bad[k]  = 0;
            rx_byte[k] = '0;
            if (bq[k].size() == 0) begin
                chk("unexpected byte", 1, 0);
                rx_have[k] = 1'b0;
            end else begin
                rx_exp[k]  = bq[k].pop_front();
                rx_have[k] = 1'b1;
            end
        end
        if (rx_busy[k]) begin
            pos = rx_cnt[k] / c;
            if (pos == 0) e = 1'b0;
            else if (pos >= 9) e = 1'b1;
            else e = rx_exp[k][pos-1];
            if (rx_have[k] && t !== e) rx_bad[k]++;
            if (pos >= 1 && pos <= 8 && (rx_cnt[k] % c) == c / 2) rx_byte[k][pos-1] = t;
            if (rx_cnt[k] == 10 * c - 1) begin
                if (rx_have[k]) begin
                    chk("decoded byte", 32'(rx_byte[k]), 32'(rx_exp[k]));
                    chk("frame bit timing", rx_bad[k], 0);
                end
                rx_busy[k] = 1'b0;
            end else begin
                rx_cnt[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst0, tx0, act0, sub0, done0);
        mon(1, rst1, tx1, act1, sub1, done1);
    end

    task automatic reset0(input int n);
        rst0 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst0   = 1'b0;
        m_sub  = 0;
        m_done = 0;
        chk("reset tx", 32'(tx0), 1);
        chk("reset active", 32'(act0), 0);
        chk("reset subunit", 32'(sub0), 0);
        chk("reset busy", 32'(busy0), 0);
        chk("reset done", 32'(done0), 0);
    endtask

    // mode 0: one-cycle pulse; 1: toggle req during the message; 2: random hold length
    task automatic send0(input int mode);
        bit acc;
        int n;
        int nb;
        acc = (m_done == 0);
        nb  = 0;
        @(posedge clk);
        #1;
        req0 = 1'b1;
        chk("tx idle before accept", 32'(tx0), 1);
        chk("busy before accept", 32'(busy0), 32'(m_done));
        if (acc) push_msg(0, m_sub, 0);
        @(posedge clk);
        #1;
        chk("tx one cycle after accept", 32'(tx0), acc ? 0 : 1);
        n = (mode == 1) ? 90 * C0 - 10 : ((mode == 2) ? $urandom_range(0, 30) : 0);
        for (int i = 0; i < n; i++) begin
            req0 = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy0 !== 1'b1) nb++;
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        if (mode == 1) chk("busy during msg", nb, 0);
        repeat (90 * C0 + 1 - n) @(posedge clk);
        #1;
        if (acc) begin
            if (m_sub == 3) m_done = 1;
            else m_sub++;
        end
    endtask

    task automatic seq0();
        int base;
        int bad;
        int n;
        reset0(3);
        send0(0);
        chk("subunit after first msg", 32'(sub0), 1);
        send0(1);
        repeat (20) @(posedge clk);
        #1;
        chk("no extra msg after toggling", 32'(act0), 0);

        // Abort during the data bits of byte 4.
        @(posedge clk);
        #1;
        req0 = 1'b1;
        push_msg(0, m_sub, 0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (41 * C0 + $urandom_range(0, 8 * C0 - 1)) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset tx", 32'(tx0), 1);
        chk("midreset active", 32'(act0), 0);
        chk("midreset subunit", 32'(sub0), 0);
        chk("midreset busy", 32'(busy0), 0);
        chk("midreset done", 32'(done0), 0);
        reset0(1);

        // Request held high from reset release: four messages then done.
        base = sub3cnt;
        req0 = 1'b1;
        for (int s = 0; s < 4; s++) push_msg(0, s, (s == 0) ? 0 : 2);
        @(posedge clk);
        #1;
        chk("tx low at first edge after reset", 32'(tx0), 0);
        repeat (4 * 90 * C0 + 60) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx0 !== 1'b1 || act0 !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("idle after done", bad, 0);
        chk("done after sequence", 32'(done0), 1);
        chk("subunit after sequence", 32'(sub0), 3);
        chk("busy when done", 32'(busy0), 1);
        chk("subunit3 & active cycles", sub3cnt - base, 90 * C0);
        req0   = 1'b0;
        m_sub  = 3;
        m_done = 1;

        for (int it = 0; it < 3; it++) begin
            reset0($urandom_range(1, 3));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                send0(2);
            end
            chk("random done", 32'(done0), 32'(m_done));
            chk("random subunit", 32'(sub0), 32'(m_sub));
        end
    endtask

    task automatic seq1();
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        chk("reset tx (434)", 32'(tx1), 1);
        chk("reset busy (434)", 32'(busy1), 0);
        @(posedge clk);
        #1;
        req1 = 1'b1;
        push_msg(1, 0, 0);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        chk("tx one cycle after accept (434)", 32'(tx1), 0);
        repeat (90 * C1 + 5) @(posedge clk);
        #1;
        chk("subunit after msg (434)", 32'(sub1), 1);
        chk("done after msg (434)", 32'(done1), 0);
    endtask

    initial begin
        rst0 = 1'b1;
        req0 = 1'b0;
        rst1 = 1'b1;
        req1 = 1'b0;
        fork
            seq0();
            seq1();
        join
        repeat (5) @(posedge clk);
        #1;
        chk("pending bytes inst0", bq[0].size(), 0);
        chk("pending msgs inst0", dq[0].size(), 0);
        chk("pending bytes inst1", bq[1].size(), 0);
        chk("pending msgs inst1", dq[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rdm_tx.md
RDM_TX -- requirements
Module: rdm_tx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
- REQ-002 SHALL have port clk_50M, input, 1, the single system clock; all logic on its rising edge.
- REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port deposit_req, input, 1, request to report a deposit for the current subunit; level-sampled.
- REQ-005 SHALL have port tx, output, 1, UART serial line, 8N1, LSB first, idle high.
- REQ-006 SHALL have port RDM_active, output, 1, high while a Resource Deposition Message is on the line.
- REQ-007 SHALL have port subunit, output, 2, number of the subunit being or next to be reported.
- REQ-008 SHALL have port busy, output, 1, high when a request cannot be accepted.
- REQ-009 SHALL have port done, output, 1, sticky flag set after the message for subunit 3 completes.

Function
- REQ-010 SHALL implement states IDLE, START, DATA, STOP, FINISH.
- REQ-011 SHALL, in IDLE with deposit_req=1 and done=0, accept the request, load byte index 0 and enter START on the next edge.
- REQ-012 SHALL ignore deposit_req in any state other than IDLE, and whenever done=1.
- REQ-013 SHALL transmit the 9-byte ASCII message "RDM-SU" followed by the digit '0'+subunit (0x30..0x33), then "-#"; byte 0 is 'R' (0x52), byte 8 is '#' (0x23).
- REQ-014 SHALL drive each byte as start bit (0), 8 data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT cycles; frames back-to-back with no idle gap.
- REQ-015 SHALL drive tx low on the first cycle of START, i.e. one cycle after the accepting edge.
- REQ-016 SHALL make one message exactly 90*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- REQ-017 SHALL, after STOP of byte 8, enter FINISH for exactly one cycle, then IDLE.
- REQ-018 SHALL assert RDM_active from the first START cycle through the last stop-bit cycle of byte 8, and deassert it in FINISH.
- REQ-019 SHALL hold subunit constant while RDM_active=1.
- REQ-020 SHALL, in FINISH, increment subunit by 1 if subunit<3; if subunit=3, leave it at 3 and set done.
- REQ-021 SHALL never wrap subunit from 3 to 0 other than by reset.
- REQ-022 SHALL drive busy=1 in every state except IDLE, and also whenever done=1.
- REQ-023 SHALL drive tx=1 in IDLE and FINISH.
- REQ-024 SHALL guarantee that subunit=3 and RDM_active=1 hold together for exactly 90*CLKS_PER_BIT cycles during the final message.
- REQ-025 SHALL size the bit-period counter to hold CLKS_PER_BIT-1 without overflow.
- REQ-026 SHALL use a 4-bit byte index (0..8) and a 3-bit data-bit index (0..7).

Reset
- REQ-027 SHALL, when reset=1 on a clock edge, force state IDLE, tx=1, RDM_active=0, subunit=0, busy=0, done=0, and clear all counters.
- REQ-028 SHALL give reset priority over every other event, including mid-frame, mid-message and in FINISH; an aborted message is not resumed and subunit does not advance.
- REQ-029 SHALL accept a new request at the first edge after reset deasserts if deposit_req=1.

Verification
- REQ-030 SHALL cover this single-message case: CLKS_PER_BIT=4, reset, then deposit_req pulsed 1 cycle -> tx low 1 cycle later; the decoded bytes are 52 44 4D 2D 53 55 30 2D 23; RDM_active is high for 360 cycles; subunit is 1 afterwards.
- REQ-031 SHALL cover this full sequence: deposit_req held high -> four messages with digits '0','1','2','3', each separated by 1 FINISH cycle plus 1 IDLE cycle; done=1 with subunit=3 after the fourth; tx stays idle high afterwards.
- REQ-032 SHALL cover this busy case: deposit_req toggled during a message -> no effect; busy=1 throughout; no extra message is sent.
- REQ-033 SHALL cover this mid-operation reset: reset asserted during byte 4 data bits -> next cycle tx=1, RDM_active=0, subunit=0, state IDLE.
- REQ-034 SHALL cover this resolved check: during the subunit-3 message, subunit==3 and RDM_active is true for exactly 360 cycles (CLKS_PER_BIT=4), and never true at any other time.
- REQ-035 SHALL cover this timing check: default CLKS_PER_BIT=434 -> every bit period measured on tx is 434 cycles.
